shift_sched: RTL
================

# shift_sched

Round-robin scheduler that shares one pipelined 32-bit logical-left barrel shifter (stages 16/8/4/2/1, zero fill) between two requesters. It accepts requests over valid/ready, issues at most one operation per cycle to the shifter and tracks each in-flight operation with an ID pipeline matched to the shifter latency. It routes each result back to the requester that issued it. It sits between the datapath clients and the shifter core and provides a drain mechanism for quiescing the shifter.

## Interface
Parameters:
- LAT, 5, shifter latency in cycles from `sh_valid_o` high to the corresponding `sh_result_i`; legal range 1..8.

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle (combinational grant)
- req0_data / req1_data  in  32  operand
- req0_amt / req1_amt  in  5  left-shift amount
- sh_valid_o  out  1  operation issued to shifter this cycle
- sh_data_o  out  32  operand to shifter
- sh_amt_o  out  5  shift amount to shifter
- sh_result_i  in  32  shifter output, valid LAT cycles after issue
- rsp0_valid / rsp1_valid  out  1  result for that requester (one-cycle pulse, no backpressure)
- rsp_data  out  32  result, shared by both responders
- drain_i  in  1  request to stop accepting new work
- drained_o  out  1  no new acceptance and pipeline empty
- stat0_cnt / stat1_cnt  out  16  grant counters (only with SHIFT_SCHED_STATS_EN)

## Operation
- Arbitration: round-robin with a priority pointer `last` (reset 1, so requester 0 wins first).
  - Only one requester valid: that requester is granted.
  - Both valid: the one not equal to `last` is granted.
  - `last` updates only on an accepted handshake.
- `reqK_ready` = grant to K AND state == RUN. It is never high for a requester whose valid is low.
- Issue: on handshake, register operand, amount and id. `sh_valid_o` is high the next cycle for exactly one cycle per handshake.
- ID pipeline: LAT-deep shift register of {valid, id}, loaded from the issue stage.
  - When its tail is valid, capture `sh_result_i` into `rsp_data` and pulse `rsp<id>_valid` the following cycle.
  - `sh_result_i` is ignored when the tail is invalid.
- State machine:
  - RUN: normal acceptance. `drain_i` high -> DRAIN. An acceptance in the same cycle is still honoured, because ready is evaluated in RUN.
  - DRAIN: no acceptance. When issue stage, ID pipeline and response register are all empty -> DRAINED.
  - DRAINED: `drained_o`=1. `drain_i` low -> RUN.
  - In DRAIN, `drain_i` low -> RUN immediately.
- Ordering: results return in issue order, with no reordering between requesters.
- Reset values (all outputs 0 except as noted): `reqK_ready` 0, `sh_valid_o` 0, `sh_data_o` 0, `sh_amt_o` 0, `rspK_valid` 0, `rsp_data` 0, `drained_o` 0, state RUN, `last` 1, ID pipeline invalid, counters 0.
- Reset mid-operation: all in-flight operations are discarded and no response pulses follow. Results still emerging from the shifter are ignored because tags are cleared.

## Timing
- Handshake at edge N: `sh_valid_o` high in cycle N+1; `sh_result_i` sampled at end of cycle N+LAT; `rspK_valid` high in cycle N+LAT+1. Total latency LAT+1 cycles after the accepting edge.
- Throughput: one operation per cycle sustained. With both requesters continuously valid, grants alternate 0,1,0,1.
- `reqK_ready` depends combinationally on `reqK_valid`, `last` and state only, never on `sh_result_i`.
- The DRAIN->DRAINED transition occurs on the first edge where all valid bits are 0. `drained_o` is registered, high from the cycle after that edge.
- Simultaneous `rst` and any other input: reset wins.

## Configuration
- `SHIFT_SCHED_STATS_EN` defined: `stat0_cnt` and `stat1_cnt` increment on each accepted handshake of that requester, saturate at 16'hFFFF, and clear on reset.
- Not defined: the ports are absent and no counter logic is generated. Arbitration and timing are identical in both cases.

## Test plan
- Single request, LAT=5: req0 data 32'h0000_0001, amt 31 accepted at edge N -> `rsp0_valid` high in cycle N+6, `rsp_data` 32'h8000_0000; `rsp1_valid` stays 0.
- Both valid for 4 cycles after reset, req0 amt 4 data 32'hF000_000F, req1 amt 8 data 32'h1234_5678 -> grants 0,1,0,1; responses alternate 32'h0000_00F0 (rsp0) and 32'h3456_7800 (rsp1).
- Drain: issue 3 ops, then raise `drain_i` -> no ready while draining; all 3 responses delivered; `drained_o` high 1 cycle after the last response register clears; drop `drain_i` -> ready resumes next cycle.
- Reset mid-flight: 3 ops outstanding, assert `rst` one cycle -> no `rspK_valid` afterwards even though the shifter still outputs data; the first post-reset grant goes to requester 0.
- Amount 0 and 31 with data 32'hFFFF_FFFF -> 32'hFFFF_FFFF and 32'h8000_0000 respectively.
- With `SHIFT_SCHED_STATS_EN`: 70000 req1 grants -> `stat1_cnt` holds 16'hFFFF, `stat0_cnt` 0.

Source files
------------

// File: rtl/shift_sched.sv
// Round-robin scheduler sharing one pipelined left shifter between two requesters.
// Optional grant counters are enabled with SHIFT_SCHED_STATS_EN.
module shift_sched #(
  parameter int LAT = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_data,
  input  logic [4:0]  req0_amt,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_data,
  input  logic [4:0]  req1_amt,
  output logic        sh_valid_o,
  output logic [31:0] sh_data_o,
  output logic [4:0]  sh_amt_o,
  input  logic [31:0] sh_result_i,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic [31:0] rsp_data,
  input  logic        drain_i,
  output logic        drained_o
`ifdef SHIFT_SCHED_STATS_EN
  ,
  output logic [15:0] stat0_cnt,
  output logic [15:0] stat1_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DRAINED = 2'd2
  } state_e;

  state_e          state_r;
  state_e          state_next_s;
  logic            last_r;
  logic            grant_v_s;
  logic            grant_id_s;
  logic            run_s;
  logic            hs_s;
  logic            busy_s;
  logic [LAT-1:0]  pipe_v_r;
  logic [LAT-1:0]  pipe_id_r;
  logic [31:0]     data_r;
  logic [4:0]      amt_r;
  logic            rsp0_r;
  logic            rsp1_r;
  logic [31:0]     rsp_data_r;
  logic            drained_r;

  // Round-robin pick: with both valid, the requester that did not win last time goes.
  always_comb begin
    grant_v_s  = 1'b0;
    grant_id_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_v_s  = 1'b1;
      grant_id_s = ~last_r;
    end else if (req0_valid) begin
      grant_v_s  = 1'b1;
      grant_id_s = 1'b0;
    end else if (req1_valid) begin
      grant_v_s  = 1'b1;
      grant_id_s = 1'b1;
    end else begin
      grant_v_s  = 1'b0;
      grant_id_s = 1'b0;
    end
  end

  assign run_s      = (state_r == ST_RUN);
  assign hs_s       = grant_v_s && run_s;
  assign req0_ready = hs_s && !grant_id_s;
  assign req1_ready = hs_s && grant_id_s;
  assign busy_s     = (|pipe_v_r) || rsp0_r || rsp1_r;

  // Drain control: leave DRAIN as soon as the request drops, even if not yet empty.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (drain_i) state_next_s = ST_DRAIN;
        else         state_next_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (!drain_i)     state_next_s = ST_RUN;
        else if (!busy_s) state_next_s = ST_DRAINED;
        else              state_next_s = ST_DRAIN;
      end
      ST_DRAINED: begin
        if (!drain_i) state_next_s = ST_RUN;
        else          state_next_s = ST_DRAINED;
      end
      default: state_next_s = ST_RUN;
    endcase
  end

  // State register, arbitration pointer and drained flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_RUN;
      last_r    <= 1'b1;
      drained_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      drained_r <= (state_next_s == ST_DRAINED);
      if (hs_s) last_r <= grant_id_s;
    end
  end

  // Issue register and ID pipeline; stage 0 doubles as the shifter's valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r    <= 32'd0;
      amt_r     <= 5'd0;
      pipe_v_r  <= '0;
      pipe_id_r <= '0;
    end else begin
      if (hs_s) begin
        data_r <= grant_id_s ? req1_data : req0_data;
        amt_r  <= grant_id_s ? req1_amt  : req0_amt;
      end
      pipe_v_r[0]  <= hs_s;
      pipe_id_r[0] <= grant_id_s;
      for (int i = 1; i < LAT; i++) begin
        pipe_v_r[i]  <= pipe_v_r[i-1];
        pipe_id_r[i] <= pipe_id_r[i-1];
      end
    end
  end

  // Response capture: the shifter output is only trusted when the tail tag is live.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_r     <= 1'b0;
      rsp1_r     <= 1'b0;
      rsp_data_r <= 32'd0;
    end else begin
      rsp0_r <= pipe_v_r[LAT-1] && !pipe_id_r[LAT-1];
      rsp1_r <= pipe_v_r[LAT-1] &&  pipe_id_r[LAT-1];
      if (pipe_v_r[LAT-1]) rsp_data_r <= sh_result_i;
    end
  end

  assign sh_valid_o = pipe_v_r[0];
  assign sh_data_o  = data_r;
  assign sh_amt_o   = amt_r;
  assign rsp0_valid = rsp0_r;
  assign rsp1_valid = rsp1_r;
  assign rsp_data   = rsp_data_r;
  assign drained_o  = drained_r;

`ifdef SHIFT_SCHED_STATS_EN
  logic [15:0] stat0_r;
  logic [15:0] stat1_r;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating per-requester grant counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat0_r <= 16'd0;
      stat1_r <= 16'd0;
    end else begin
      if (req0_ready) stat0_r <= sat_inc(stat0_r);
      if (req1_ready) stat1_r <= sat_inc(stat1_r);
    end
  end

  assign stat0_cnt = stat0_r;
  assign stat1_cnt = stat1_r;
`endif

endmodule
